// File: rtl/apb2axi_read_collector.sv
// Snoops AR handshakes for per-tag burst length, steers R beats into the read data buffer
// and emits one completion record per burst on RLAST.
module apb2axi_read_collector #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  ar_mon_vld,
    input  logic                  ar_mon_rdy,
    input  logic [AXI_ID_W-1:0]   ar_mon_id,
    input  logic [3:0]            ar_mon_len,
    input  logic [AXI_ID_W-1:0]   rid,
    input  logic [AXI_DATA_W-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  buf_wr_en,
    output logic [AXI_ID_W-1:0]   buf_wr_tag,
    output logic [3:0]            buf_wr_beat,
    output logic [AXI_DATA_W-1:0] buf_wr_data,
    output logic                  cpl_valid,
    input  logic                  cpl_ready,
    output logic [AXI_ID_W-1:0]   cpl_tag,
    output logic [1:0]            cpl_resp,
    output logic [4:0]            cpl_beats,
    output logic                  cpl_len_err,
    output logic                  stray_err,
    output logic                  dup_err,
    output logic [AXI_ID_W:0]     outstanding_cnt
);
    localparam int NUM_TAGS = 2 ** AXI_ID_W;
    localparam int CNT_W    = AXI_ID_W + 1;

    logic [NUM_TAGS-1:0] outst;
    logic [NUM_TAGS-1:0] outst_nxt;
    logic [3:0]          exp_len  [NUM_TAGS];
    logic [4:0]          beat_cnt [NUM_TAGS];
    logic [1:0]          resp_acc [NUM_TAGS];

    logic ar_hs;
    logic r_hs;
    logic r_hit;
    logic r_last_hit;
    logic cpl_hs;

    function automatic logic [4:0] sat_inc16(input logic [4:0] v);
        return (v >= 5'd16) ? 5'd16 : v + 5'd1;
    endfunction

    // Response codes are ordered by severity numerically, so the worst is the maximum.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_TAGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_TAGS; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // Backpressure comes only from a completion record that cannot drain.
    assign rready     = aresetn && !(cpl_valid && !cpl_ready);
    assign ar_hs      = ar_mon_vld && ar_mon_rdy;
    assign r_hs       = rvalid && rready;
    assign r_hit      = r_hs && outst[rid];
    assign r_last_hit = r_hit && rlast;
    assign cpl_hs     = cpl_valid && cpl_ready;

    // An AR on the same tag as a closing RLAST opens a new burst, so it is applied last.
    always_comb begin
        outst_nxt = outst;
        if (r_last_hit) outst_nxt[rid] = 1'b0;
        if (ar_hs) outst_nxt[ar_mon_id] = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outst <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                exp_len[i]  <= '0;
                beat_cnt[i] <= '0;
                resp_acc[i] <= '0;
            end
        end else begin
            outst <= outst_nxt;
            if (r_hit) begin
                beat_cnt[rid] <= sat_inc16(beat_cnt[rid]);
                resp_acc[rid] <= resp_max(resp_acc[rid], rresp);
            end
            if (ar_hs) begin
                exp_len[ar_mon_id]  <= ar_mon_len;
                beat_cnt[ar_mon_id] <= '0;
                resp_acc[ar_mon_id] <= '0;
            end
        end
    end

    // Output register stage: everything below appears one cycle after acceptance.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_wr_en       <= 1'b0;
            buf_wr_tag      <= '0;
            buf_wr_beat     <= '0;
            buf_wr_data     <= '0;
            cpl_valid       <= 1'b0;
            cpl_tag         <= '0;
            cpl_resp        <= '0;
            cpl_beats       <= '0;
            cpl_len_err     <= 1'b0;
            stray_err       <= 1'b0;
            dup_err         <= 1'b0;
            outstanding_cnt <= '0;
        end else begin
            buf_wr_en       <= r_hit && (beat_cnt[rid] <= {1'b0, exp_len[rid]});
            stray_err       <= r_hs && !outst[rid];
            dup_err         <= ar_hs && outst[ar_mon_id];
            outstanding_cnt <= popcount(outst_nxt);
            if (r_hit) begin
                buf_wr_tag  <= rid;
                buf_wr_beat <= beat_cnt[rid][3:0];
                buf_wr_data <= rdata;
            end
            if (r_last_hit) begin
                cpl_valid   <= 1'b1;
                cpl_tag     <= rid;
                cpl_resp    <= resp_max(resp_acc[rid], rresp);
                cpl_beats   <= sat_inc16(beat_cnt[rid]);
                cpl_len_err <= (beat_cnt[rid] != {1'b0, exp_len[rid]});
            end else if (cpl_hs) begin
                cpl_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb2axi_read_collector.sv
// Bench for apb2axi_read_collector: vector table, directed corner sequences and random traffic
// checked against a transaction-level model of per-tag bursts and a completion queue.
module tb_apb2axi_read_collector;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ar_mon_vld = 1'b0, ar_mon_rdy = 1'b0;
    logic [3:0]  ar_mon_id = '0, ar_mon_len = '0;
    logic [3:0]  rid = '0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;
    logic        buf_wr_en;
    logic [3:0]  buf_wr_tag, buf_wr_beat;
    logic [63:0] buf_wr_data;
    logic        cpl_valid, cpl_ready = 1'b0;
    logic [3:0]  cpl_tag;
    logic [1:0]  cpl_resp;
    logic [4:0]  cpl_beats;
    logic        cpl_len_err, stray_err, dup_err;
    logic [4:0]  outstanding_cnt;

    always #5 aclk = ~aclk;

    apb2axi_read_collector #(.AXI_ID_W(4), .AXI_DATA_W(64)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ar_mon_vld(ar_mon_vld), .ar_mon_rdy(ar_mon_rdy), .ar_mon_id(ar_mon_id), .ar_mon_len(ar_mon_len),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .buf_wr_en(buf_wr_en), .buf_wr_tag(buf_wr_tag), .buf_wr_beat(buf_wr_beat), .buf_wr_data(buf_wr_data),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_resp(cpl_resp),
        .cpl_beats(cpl_beats), .cpl_len_err(cpl_len_err),
        .stray_err(stray_err), .dup_err(dup_err), .outstanding_cnt(outstanding_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: per-tag burst bookkeeping plus a queue of completions not yet taken.
    typedef struct { logic [3:0] tag; logic [1:0] resp; logic [4:0] beats; logic len_err; } cpl_t;
    cpl_t cq[$];
    bit   m_outst [16];
    int   m_len   [16];
    int   m_cnt   [16];
    int   m_worst [16];

    typedef struct {
        logic arv; logic [3:0] arid; logic [3:0] arlen;
        logic rv; logic [3:0] rid; logic [1:0] rr; logic rl;
        logic e_en; logic [3:0] e_beat; logic e_stray; logic e_dup; logic e_cplv;
        logic [1:0] e_resp; logic [4:0] e_beats; logic e_lerr; logic [4:0] e_cnt;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_outst[i] = 0; m_len[i] = 0; m_cnt[i] = 0; m_worst[i] = 0;
        end
        cq.delete();
    endtask

    // Drive one cycle from a falling edge, predict, then compare on the next falling edge.
    task automatic step(input bit arv, input bit ardy, input int arid, input int arlen,
                        input bit rv, input int r_id, input logic [63:0] rd, input int rr,
                        input bit rl, input bit crdy, output bit acc);
        bit   exp_rr, e_en, e_stray, e_dup;
        int   e_beat, e_cnt;
        cpl_t c;
        ar_mon_vld = arv; ar_mon_rdy = ardy; ar_mon_id = 4'(arid); ar_mon_len = 4'(arlen);
        rvalid = rv; rid = 4'(r_id); rdata = rd; rresp = 2'(rr); rlast = rl; cpl_ready = crdy;
        #1;
        exp_rr = !(cq.size() > 0 && !crdy);
        chk("rready", 64'(rready), 64'(exp_rr));
        acc = rv && exp_rr;
        e_dup = arv && ardy && m_outst[arid];
        e_en = 0; e_stray = 0; e_beat = 0;
        if (cq.size() > 0 && crdy) void'(cq.pop_front());
        if (acc && !m_outst[r_id]) begin
            e_stray = 1;
        end else if (acc) begin
            if (m_cnt[r_id] <= m_len[r_id]) begin
                e_en = 1; e_beat = m_cnt[r_id];
            end
            m_cnt[r_id]++;
            if (rr > m_worst[r_id]) m_worst[r_id] = rr;
            if (rl) begin
                c.tag = 4'(r_id);
                c.resp = 2'(m_worst[r_id]);
                c.beats = 5'((m_cnt[r_id] > 16) ? 16 : m_cnt[r_id]);
                c.len_err = (m_cnt[r_id] != m_len[r_id] + 1);
                cq.push_back(c);
                m_outst[r_id] = 0;
            end
        end
        if (arv && ardy) begin
            m_outst[arid] = 1; m_len[arid] = arlen; m_cnt[arid] = 0; m_worst[arid] = 0;
        end
        e_cnt = 0;
        for (int i = 0; i < 16; i++) e_cnt += int'(m_outst[i]);
        @(posedge aclk);
        @(negedge aclk);
        chk("buf_wr_en", 64'(buf_wr_en), 64'(e_en));
        if (e_en) begin
            chk("buf_wr_tag", 64'(buf_wr_tag), 64'(r_id));
            chk("buf_wr_beat", 64'(buf_wr_beat), 64'(e_beat));
            chk("buf_wr_data", buf_wr_data, rd);
        end
        chk("stray_err", 64'(stray_err), 64'(e_stray));
        chk("dup_err", 64'(dup_err), 64'(e_dup));
        chk("outstanding_cnt", 64'(outstanding_cnt), 64'(e_cnt));
        chk("cpl_valid", 64'(cpl_valid), 64'(cq.size() > 0));
        if (cq.size() > 0) begin
            chk("cpl_tag", 64'(cpl_tag), 64'(cq[0].tag));
            chk("cpl_resp", 64'(cpl_resp), 64'(cq[0].resp));
            chk("cpl_beats", 64'(cpl_beats), 64'(cq[0].beats));
            chk("cpl_len_err", 64'(cpl_len_err), 64'(cq[0].len_err));
        end
    endtask

    task automatic idle(input bit crdy);
        bit a;
        step(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, crdy, a);
    endtask

    task automatic ar(input int id, input int len);
        bit a;
        step(1, 1, id, len, 0, 0, 64'h0, 0, 0, 1, a);
    endtask

    task automatic beat(input int id, input int rr, input bit last);
        bit a;
        int n;
        logic [63:0] d;
        d = {$urandom, $urandom};
        n = 0;
        do begin
            step(0, 0, 0, 0, 1, id, d, rr, last, 1, a);
            n++;
        end while (!a && n < 20);
        if (!a) begin
            checks++; failures++;
            $display("FAIL beat_accept id=%0d not accepted within 20 cycles", id);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rready"}, 64'(rready), 64'h0);
        chk({tag, "_buf_wr_en"}, 64'(buf_wr_en), 64'h0);
        chk({tag, "_buf_wr_tag"}, 64'(buf_wr_tag), 64'h0);
        chk({tag, "_buf_wr_beat"}, 64'(buf_wr_beat), 64'h0);
        chk({tag, "_buf_wr_data"}, buf_wr_data, 64'h0);
        chk({tag, "_cpl_valid"}, 64'(cpl_valid), 64'h0);
        chk({tag, "_cpl_fields"}, 64'({cpl_tag, cpl_resp, cpl_beats, cpl_len_err}), 64'h0);
        chk({tag, "_errs"}, 64'({stray_err, dup_err}), 64'h0);
        chk({tag, "_outstanding_cnt"}, 64'(outstanding_cnt), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int r_id, pick;
        bit rl;
        model_reset();
        rvalid = 1'b1;
        #2;
        chk_zero("por");
        rvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;

        // arv arid arlen | rv rid rr rl | en beat stray dup cplv resp beats lerr cnt
        tbl[0]  = '{1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 1, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 1, 3, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{0, 0, 0, 1, 3, 0, 1, 1, 3, 0, 0, 1, 0, 4, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 1, 3, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 1, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 1, 3, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 1, 3, 5, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].arv, tbl[i].arv, int'(tbl[i].arid), int'(tbl[i].arlen), tbl[i].rv,
                 int'(tbl[i].rid), 64'hD0D0_0000 + 64'(i), int'(tbl[i].rr), tbl[i].rl, 1, a);
            chk($sformatf("tbl%0d_en", i), 64'(buf_wr_en), 64'(tbl[i].e_en));
            if (tbl[i].e_en) begin
                chk($sformatf("tbl%0d_beat", i), 64'(buf_wr_beat), 64'(tbl[i].e_beat));
                chk($sformatf("tbl%0d_tag", i), 64'(buf_wr_tag), 64'(tbl[i].rid));
            end
            chk($sformatf("tbl%0d_stray", i), 64'(stray_err), 64'(tbl[i].e_stray));
            chk($sformatf("tbl%0d_dup", i), 64'(dup_err), 64'(tbl[i].e_dup));
            chk($sformatf("tbl%0d_cplv", i), 64'(cpl_valid), 64'(tbl[i].e_cplv));
            if (tbl[i].e_cplv) begin
                chk($sformatf("tbl%0d_cpl", i), 64'({cpl_tag, cpl_resp, cpl_beats, cpl_len_err}),
                    64'({tbl[i].rid, tbl[i].e_resp, tbl[i].e_beats, tbl[i].e_lerr}));
            end
            chk($sformatf("tbl%0d_cnt", i), 64'(outstanding_cnt), 64'(tbl[i].e_cnt));
        end

        // Interleaved bursts on two ids.
        ar(1, 1); ar(2, 1);
        beat(2, 0, 0); beat(1, 0, 0); beat(2, 0, 1);
        chk("ilv_first_tag", 64'(cpl_tag), 64'd2);
        beat(1, 0, 1);
        chk("ilv_second_tag", 64'(cpl_tag), 64'd1);
        chk("ilv_second_beats", 64'(cpl_beats), 64'd2);
        idle(1);

        // Worst-response merge, then an early RLAST.
        ar(5, 2);
        beat(5, 0, 0); beat(5, 2, 0); beat(5, 0, 1);
        chk("merge_resp", 64'(cpl_resp), 64'd2);
        ar(5, 3);
        beat(5, 0, 0); beat(5, 1, 1);
        chk("early_beats", 64'(cpl_beats), 64'd2);
        chk("early_len_err", 64'(cpl_len_err), 64'd1);
        idle(1);

        // Completion backpressure stalls R without losing the beat.
        ar(1, 0); ar(2, 0);
        step(0, 0, 0, 0, 1, 1, 64'h1111, 0, 1, 0, a);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0, 1, 2, 64'h2222, 0, 1, 0, a);
            chk("bp_rready_low", 64'(rready), 64'd0);
            chk("bp_cpl_held", 64'(cpl_tag), 64'd1);
        end
        step(0, 0, 0, 0, 1, 2, 64'h2222, 0, 1, 1, a);
        chk("bp_second_cpl", 64'({cpl_valid, cpl_tag}), 64'({1'b1, 4'd2}));
        idle(1);

        // Beat count saturation on a long overrun, and a full 16-beat burst.
        ar(6, 1);
        for (int k = 0; k < 17; k++) beat(6, 0, 0);
        beat(6, 0, 1);
        chk("sat_beats", 64'(cpl_beats), 64'd16);
        ar(9, 15);
        for (int k = 0; k < 16; k++) beat(9, 1, k == 15);
        chk("full_beats", 64'({cpl_beats, cpl_len_err}), 64'({5'd16, 1'b0}));
        idle(1);

        // AR and closing RLAST on the same tag in one cycle.
        ar(2, 0);
        step(1, 1, 2, 1, 1, 2, 64'h3333, 0, 1, 1, a);
        chk("same_dup", 64'(dup_err), 64'd1);
        chk("same_cnt", 64'(outstanding_cnt), 64'd1);
        beat(2, 0, 0); beat(2, 0, 1);
        chk("same_new_burst", 64'({cpl_tag, cpl_beats, cpl_len_err}), 64'({4'd2, 5'd2, 1'b0}));
        idle(1);

        // Reset in the middle of a burst.
        ar(4, 3);
        beat(4, 0, 0); beat(4, 0, 0);
        rvalid = 1'b1;
        aresetn = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        rvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        ar(4, 1);
        beat(4, 3, 0); beat(4, 0, 1);
        chk("post_rst_cpl", 64'({cpl_tag, cpl_resp, cpl_beats, cpl_len_err}), 64'({4'd4, 2'd3, 5'd2, 1'b0}));

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r_id = int'($urandom % 8);
            pick = -1;
            if ($urandom % 4 != 0)
                for (int k = 0; k < 8; k++)
                    if (pick < 0 && m_outst[(r_id + k) % 8]) pick = (r_id + k) % 8;
            if (pick >= 0) r_id = pick;
            if (m_outst[r_id] && m_cnt[r_id] >= m_len[r_id]) rl = ($urandom % 8 != 0);
            else rl = ($urandom % 12 == 0);
            step($urandom % 5 == 0, $urandom % 4 != 0, int'($urandom % 8), int'($urandom % 4),
                 $urandom % 3 != 0, r_id, {$urandom, $urandom}, int'($urandom % 4), rl,
                 $urandom % 4 != 0, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
